// File: rtl/can_uart_framer.sv
// rtl/can_uart_framer.sv - serialises one latched CAN frame into bytes for the UART TX stage
// Define CAN_UART_FRAMER_CHECKSUM_EN to append an XOR checksum byte (B1..last data byte).
module can_uart_framer (
  input  logic        clock115200hz,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [10:0] frame_id,
  input  logic        frame_rtr,
  input  logic [3:0]  frame_dlc,
  input  logic [63:0] frame_data,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_t;

  state_t      state, state_nxt;
  logic [10:0] id_q;
  logic        rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic [3:0]  idx;
  logic [3:0]  last_idx;
  logic [3:0]  len;
  logic [3:0]  dlc_clamped;
  logic [2:0]  dsel;
  logic [7:0]  byte_cur;
  logic        accept;
  logic        send_nxt;

  assign dlc_clamped = (frame_dlc > 4'd8) ? 4'd8 : frame_dlc;
  assign len         = rtr_q ? 4'd0 : dlc_q;
  assign frame_ready = (state == S_IDLE) && !reset;
  assign accept      = frame_valid && frame_ready;
  assign busy        = (state != S_IDLE);
  assign dsel        = idx[2:0] - 3'd4;

`ifdef CAN_UART_FRAMER_CHECKSUM_EN
  logic [7:0] csum;
  assign last_idx = 4'd4 + len;
`else
  assign last_idx = 4'd3 + len;
`endif

  always_comb begin
    byte_cur = data_q[{dsel, 3'b000} +: 8];
    case (idx)
      4'd0:    byte_cur = 8'hAA;
      4'd1:    byte_cur = {rtr_q, 4'b0000, id_q[10:8]};
      4'd2:    byte_cur = id_q[7:0];
      4'd3:    byte_cur = {4'b0000, dlc_q};
      default: ;
    endcase
`ifdef CAN_UART_FRAMER_CHECKSUM_EN
    if (idx == last_idx) byte_cur = csum;
`endif
  end

  // tx_send is held in ISSUE for its single high cycle so it never leaks into other states
  always_comb begin
    state_nxt = state;
    send_nxt  = 1'b0;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (tx_send)       state_nxt = S_WAIT_BUSY;
        else if (tx_ready) send_nxt  = 1'b1;
      end
      S_WAIT_BUSY: if (!tx_ready) state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (tx_ready) state_nxt = (idx == last_idx) ? S_IDLE : S_LOAD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock115200hz) begin
    if (reset) begin
      state   <= S_IDLE;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
      idx     <= 4'd0;
      id_q    <= 11'd0;
      rtr_q   <= 1'b0;
      dlc_q   <= 4'd0;
      data_q  <= 64'd0;
`ifdef CAN_UART_FRAMER_CHECKSUM_EN
      csum    <= 8'h00;
`endif
    end else begin
      state   <= state_nxt;
      tx_send <= send_nxt;
      if (accept) begin
        id_q   <= frame_id;
        rtr_q  <= frame_rtr;
        dlc_q  <= dlc_clamped;
        data_q <= frame_data;
        idx    <= 4'd0;
`ifdef CAN_UART_FRAMER_CHECKSUM_EN
        csum   <= 8'h00;
`endif
      end
      if (state == S_LOAD) begin
        tx_data <= byte_cur;
`ifdef CAN_UART_FRAMER_CHECKSUM_EN
        if (idx != 4'd0) csum <= csum ^ byte_cur;
`endif
      end
      if (state == S_WAIT_IDLE && tx_ready) idx <= idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_can_uart_framer.sv
// tb/tb_can_uart_framer.sv - scoreboard bench for can_uart_framer with a UART TX stage model
// Expected frames follow CAN_UART_FRAMER_CHECKSUM_EN the same way the design does.
module tb_can_uart_framer;

`ifdef CAN_UART_FRAMER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        clock115200hz = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [10:0] frame_id = 11'd0;
  logic        frame_rtr = 1'b0;
  logic [3:0]  frame_dlc = 4'd0;
  logic [63:0] frame_data = 64'd0;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready = 1'b1;
  logic        busy;

  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int unstable = 0;
  int bit_cycles = 9;

  can_uart_framer dut (
    .clock115200hz(clock115200hz),
    .reset(reset),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_id(frame_id),
    .frame_rtr(frame_rtr),
    .frame_dlc(frame_dlc),
    .frame_data(frame_data),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_ready(tx_ready),
    .busy(busy)
  );

  always #5 clock115200hz = ~clock115200hz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UART TX stage: ready stays high one cycle after taking send, then low for bit_cycles
  int phase = 0;
  int cnt = 0;
  always begin
    @(posedge clock115200hz);
    #2;
    if (reset) begin
      tx_ready = 1'b1;
      phase = 0;
    end else begin
      case (phase)
        0: if (tx_send) phase = 1;
        1: begin tx_ready = 1'b0; cnt = bit_cycles; phase = 2; end
        default: begin
          cnt--;
          if (cnt == 0) begin tx_ready = 1'b1; phase = 0; end
        end
      endcase
    end
  end

  logic [7:0] held = 8'h00;
  logic [7:0] exp_b;
  bit holding = 1'b0;
  bit prev_send = 1'b0;
  always @(negedge clock115200hz) begin
    if (reset) begin
      holding = 1'b0;
      prev_send = 1'b0;
    end else begin
      if (tx_send) begin
        pulses++;
        chk("single_cycle_send", {63'd0, prev_send}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send actual=%0h required=none", tx_data);
        end else begin
          exp_b = sb.pop_front();
          chk("tx_byte", tx_data, exp_b);
        end
        held = tx_data;
        holding = 1'b1;
      end
      if (holding && !tx_ready && tx_data !== held) unstable++;
      prev_send = tx_send;
    end
  end

  task automatic push(input logic [7:0] b);
    sb.push_back(b);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input bit lat);
    int n;
    n = 0;
    @(negedge clock115200hz);
    frame_id = id; frame_rtr = rtr; frame_dlc = dlc; frame_data = data;
    frame_valid = 1'b1;
    while (!frame_ready && n < 100) begin
      @(negedge clock115200hz);
      n++;
    end
    if (!frame_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=1", frame_ready);
    end
    @(posedge clock115200hz);
    #1;
    frame_valid = 1'b0;
    frame_id = ~id; frame_rtr = ~rtr; frame_dlc = ~dlc; frame_data = ~data;
    if (lat) begin
      @(posedge clock115200hz);
      #1;
      chk("start_data", tx_data, 8'hAA);
      chk("busy_in_frame", busy, 1'b1);
      chk("ready_low_in_frame", frame_ready, 1'b0);
      @(posedge clock115200hz);
      #1;
      chk("start_send", tx_send, 1'b1);
    end
  endtask

  task automatic wait_done(input int exp_n, input int p0, input int u0);
    int n;
    n = 0;
    @(negedge clock115200hz);
    while ((busy || !tx_ready) && n < 5000) begin
      @(negedge clock115200hz);
      n++;
    end
    chk("frame_done", busy, 1'b0);
    chk("queue_empty", sb.size(), 0);
    chk("pulse_count", pulses - p0, exp_n);
    chk("data_stable", unstable - u0, 0);
  endtask

  task automatic push_basic();
    push(8'hAA); push(8'h01); push(8'h23); push(8'h02); push(8'h55); push(8'hC3);
    if (CK == 1) push(8'hB6);
  endtask

  int p0, u0, n;
  initial begin
    repeat (3) @(posedge clock115200hz);
    #1;
    chk("rst_frame_ready", frame_ready, 1'b0);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clock115200hz);
    reset = 1'b0;
    @(posedge clock115200hz);
    #1;
    chk("post_rst_ready", frame_ready, 1'b1);

    // basic frame with start-latency checks
    p0 = pulses; u0 = unstable;
    push_basic();
    send_frame(11'h123, 1'b0, 4'd2, 64'h0000_0000_0000_C355, 1'b1);
    wait_done(6 + CK, p0, u0);

    // DLC clamp to 8
    p0 = pulses; u0 = unstable;
    push(8'hAA); push(8'h05); push(8'hA5); push(8'h08);
    for (int i = 1; i <= 8; i++) push(i[7:0]);
    if (CK == 1) push(8'hA0);
    send_frame(11'h5A5, 1'b0, 4'd15, 64'h0807_0605_0403_0201, 1'b0);
    wait_done(12 + CK, p0, u0);

    // RTR frame: no data bytes, B3 keeps the DLC
    p0 = pulses; u0 = unstable;
    push(8'hAA); push(8'h87); push(8'hFF); push(8'h04);
    if (CK == 1) push(8'h7C);
    send_frame(11'h7FF, 1'b1, 4'd4, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    wait_done(4 + CK, p0, u0);

    // slow TX stage
    bit_cycles = 20;
    p0 = pulses; u0 = unstable;
    push(8'hAA); push(8'h02); push(8'hB4); push(8'h03);
    push(8'h10); push(8'h20); push(8'h30);
    if (CK == 1) push(8'hB5);
    send_frame(11'h2B4, 1'b0, 4'd3, 64'h0000_0000_0030_2010, 1'b0);
    wait_done(7 + CK, p0, u0);
    bit_cycles = 9;

    // reset while B3 is in flight
    push_basic();
    send_frame(11'h123, 1'b0, 4'd2, 64'h0000_0000_0000_C355, 1'b0);
    n = 0;
    while (!(sb.size() == 2 + CK && !tx_ready) && n < 2000) begin
      @(negedge clock115200hz);
      n++;
    end
    chk("b3_in_flight", sb.size(), 2 + CK);
    @(negedge clock115200hz);
    reset = 1'b1;
    @(posedge clock115200hz);
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_tx_send", tx_send, 1'b0);
    chk("midrst_tx_data", tx_data, 8'h00);
    @(negedge clock115200hz);
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clock115200hz);

    p0 = pulses; u0 = unstable;
    push_basic();
    send_frame(11'h123, 1'b0, 4'd2, 64'h0000_0000_0000_C355, 1'b1);
    wait_done(6 + CK, p0, u0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
